clk_gen_multi: RTL and testbench
================================

# clk_gen_multi

Multi-channel, runtime-programmable clock divider; the parametrised successor to the single fixed-ratio divider. From one source clock it produces a half-rate `clock_2x` and `NUM_CH` independent 50 %-duty divided clocks. Each channel has a per-channel ratio and enable, loaded through a valid/ready config port and applied only at full-period boundaries, so no output ever glitches. A `realign` strobe restarts all channels in phase; it sits at the top of the design feeding the slow engine clock domains.

## Interface
- `NUM_CH`, 4: number of divided-clock channels (1..16).
- `CNT_W`, 6: width of ratio and counter.
- `DEFAULT_RATIO`, 5: reset half-period, in source cycles, for every channel.
- `CH_W`, 2: width of `cfg_ch`; must be at least clog2(NUM_CH), minimum 1.

Ports:
- `original_clock`  in  1  source clock; all logic on its rising edge.
- `reset_in`  in  1  reset, synchronous, active-low.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config accept, combinational: `~pending[cfg_ch]`.
- `cfg_ch`  in  CH_W  target channel.
- `cfg_ratio`  in  CNT_W  new half-period, in source cycles.
- `cfg_en`  in  1  new channel enable.
- `realign`  in  1  one-cycle strobe that restarts all channels in phase.
- `clock_2x`  out  1  toggles every source cycle.
- `clock_div`  out  NUM_CH  divided clocks, one bit per channel.
- `tick`  out  NUM_CH  one-cycle pulse, registered on the same edge as the channel's `clock_div` rises.

## Operation
- **Per-channel state:** `cnt`, `ratio_act`, `en_act`, `ratio_pend`, `en_pend`, `pending`.
- **Reset (reset_in=0 at an edge):**
  - `clock_2x`=1, `clock_div`=0, `tick`=0.
  - `cnt`=0, `ratio_act`=DEFAULT_RATIO, `en_act`=1, `pending`=0.
  - Consequently `cfg_ready`=1.
- **Counting, channel enabled:**
  - If `cnt`==`ratio_act`-1: toggle `clock_div`, set `cnt`=0.
  - Else: `cnt`+1.
  - Duty is 50 %; period is 2·ratio_act source cycles.
- **Disabled channel:** `clock_div`=0, `cnt`=0, `tick`=0, held.
- **Config accept:** on `cfg_valid & cfg_ready`:
  - Write `ratio_pend`/`en_pend` of `cfg_ch` and set `pending`.
  - `cfg_ratio`=0 is stored as 1.
  - A `cfg_ch` ≥ NUM_CH is accepted (ready=1) and dropped.
- **Config apply:**
  - Enabled channel: applied on the high→low toggle edge, i.e. `clock_div`=1 and `cnt`==`ratio_act`-1. The new ratio governs the following low phase; if `en_pend`=0, the channel stops low. A config for an enabled channel with `ratio_act`=R therefore waits at most 2R cycles.
  - Disabled channel: applied on the next edge. If enabled, the channel starts counting from `cnt`=0 with output low.
  - `pending` clears on the apply edge. `cfg_ready` for that channel returns high in the next cycle.
- **`realign`=1 at an edge, all channels:**
  - `cnt`=0, `clock_div`=0, and any pending config is applied immediately.
  - A config accepted in the same cycle as `realign` is also applied immediately, not left pending.
  - `clock_2x` is set to 1.
- **Priority:** reset > realign > apply > count.
- **Reset mid-operation:** all pending config is discarded.

## Timing
- From the first edge with `reset_in`=1 (edge 1), `clock_2x` reads 0,1,0,…
- Channel with ratio R: `clock_div` rises on edge R, falls on edge 2R, rises on edge 3R.
- `tick` is high during the cycle following edge R, 3R, 5R, …
- The same edge numbering applies after `realign` (realign edge = edge 0).
- Config latency, enabled channel:
  - Accept edge → apply edge = edges remaining to the next falling toggle (≥1).
  - Output rises R_new edges after the apply edge.
- Back-to-back configs to one channel:
  - The second stalls (`cfg_ready`=0) until the first applies.
  - Configs to different channels are accepted on consecutive cycles.
- Ratio=1: `clock_div` toggles every edge, identical to `clock_2x` phase-inverted.

## Test plan
- **Reset release, NUM_CH=4, DEFAULT_RATIO=5:**
  - All `clock_div` rise on edge 5 and fall on edge 10.
  - `tick`=4'hF for one cycle after edges 5 and 15.
  - `clock_2x` alternates starting at 0.
- **Ratio change:** ch1 config ratio=3 accepted on edge 2.
  - `cfg_ready`=0 on ch1 until the apply at edge 10.
  - Then rise at edge 13, fall at 16; ch0 is unaffected.
- **Disable then enable ch2:**
  - `en`=0 accepted on edge 7: ch2 falls on edge 10 and stays 0.
  - Re-enable with ratio 2 accepted on edge 20: applied at edge 21, rises at edge 23.
- **`realign` pulse on edge 12** with ch0 ratio 5, ch3 ratio 2:
  - Both are low after edge 12.
  - ch3 rises on edge 14, ch0 rises on edge 17, tick pulses coincide accordingly.
- **Edge cases:**
  - `cfg_ratio`=0 → behaves as ratio 1.
  - `cfg_ch`=5 with NUM_CH=4 → accepted, no channel changes.
  - `cfg_valid` held on a pending channel → no accept until apply.
- **Reset asserted mid-period with a config pending:**
  - Outputs return to reset values on that edge.
  - Pending is cleared; after release, ratio is 5 on all channels.

Source files
------------

// File: rtl/clk_gen_multi.sv
// Multi-channel runtime-programmable clock divider: a half-rate clock plus NUM_CH
// 50%-duty divided clocks whose ratio/enable change only at full-period boundaries.
module clk_gen_multi #(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 6,
    parameter int DEFAULT_RATIO = 5,
    parameter int CH_W          = 2
) (
    input  logic              original_clock,
    input  logic              reset_in,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_ratio,
    input  logic              cfg_en,
    input  logic              realign,
    output logic              clock_2x,
    output logic [NUM_CH-1:0] clock_div,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DEF_RATIO = CNT_W'(DEFAULT_RATIO);

    logic [CNT_W-1:0]  cnt        [NUM_CH];
    logic [CNT_W-1:0]  ratio_act  [NUM_CH];
    logic [CNT_W-1:0]  ratio_pend [NUM_CH];
    logic [NUM_CH-1:0] en_act;
    logic [NUM_CH-1:0] en_pend;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] sel;
    logic [CNT_W-1:0]  ratio_in;
    logic              accept;

    // Handshake: a config transfers on an edge where cfg_valid and cfg_ready are both
    // high. Ready drops only while the addressed channel holds an unapplied config;
    // out-of-range channels are always ready and their configs are discarded.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = ~pending[i];
        end
    end

    assign accept   = cfg_valid & cfg_ready;
    assign ratio_in = (cfg_ratio == '0) ? CNT_W'(1) : cfg_ratio;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i] = accept && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge original_clock) begin
        if (!reset_in) begin
            clock_2x  <= 1'b1;
            clock_div <= '0;
            tick      <= '0;
            en_act    <= '1;
            en_pend   <= '1;
            pending   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]        <= '0;
                ratio_act[i]  <= DEF_RATIO;
                ratio_pend[i] <= DEF_RATIO;
            end
        end else begin
            clock_2x <= realign ? 1'b1 : ~clock_2x;
            for (int i = 0; i < NUM_CH; i++) begin
                tick[i] <= 1'b0;
                if (realign) begin
                    // A config arriving with realign bypasses the pending slot.
                    cnt[i]       <= '0;
                    clock_div[i] <= 1'b0;
                    pending[i]   <= 1'b0;
                    if (sel[i]) begin
                        ratio_act[i] <= ratio_in;
                        en_act[i]    <= cfg_en;
                    end else if (pending[i]) begin
                        ratio_act[i] <= ratio_pend[i];
                        en_act[i]    <= en_pend[i];
                    end
                end else begin
                    if (sel[i]) begin
                        ratio_pend[i] <= ratio_in;
                        en_pend[i]    <= cfg_en;
                        pending[i]    <= 1'b1;
                    end
                    if (!en_act[i]) begin
                        cnt[i]       <= '0;
                        clock_div[i] <= 1'b0;
                        if (pending[i]) begin
                            ratio_act[i] <= ratio_pend[i];
                            en_act[i]    <= en_pend[i];
                            pending[i]   <= 1'b0;
                        end
                    end else if (cnt[i] == ratio_act[i] - 1'b1) begin
                        clock_div[i] <= ~clock_div[i];
                        tick[i]      <= ~clock_div[i];
                        cnt[i]       <= '0;
                        // Swap only at the falling toggle so the low phase uses the new ratio.
                        if (clock_div[i] && pending[i]) begin
                            ratio_act[i] <= ratio_pend[i];
                            en_act[i]    <= en_pend[i];
                            pending[i]   <= 1'b0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Table-driven bench for clk_gen_multi: per-edge vectors with hand-computed outputs,
// plus a hand-written reset-mid-period sequence.
module tb_clk_gen_multi;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_ch;
    logic [5:0] cfg_ratio;
    logic       cfg_en;
    logic       realign;
    logic       clock_2x;
    logic [3:0] clock_div;
    logic [3:0] tick;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clk_gen_multi #(
        .NUM_CH(4),
        .CNT_W(6),
        .DEFAULT_RATIO(5),
        .CH_W(3)
    ) dut (
        .original_clock(clk),
        .reset_in(reset_in),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_ratio(cfg_ratio),
        .cfg_en(cfg_en),
        .realign(realign),
        .clock_2x(clock_2x),
        .clock_div(clock_div),
        .tick(tick)
    );

    typedef struct {
        logic       rst;
        logic       valid;
        logic [2:0] ch;
        logic [5:0] ratio;
        logic       en;
        logic       rl;
        logic       chk;
        logic       exp_rdy;
        logic       exp_2x;
        logic [3:0] exp_div;
        logic [3:0] exp_tick;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic valid, input logic [2:0] ch,
                                input logic [5:0] ratio, input logic en, input logic rl,
                                input logic chk, input logic rdy, input logic x2,
                                input logic [3:0] div, input logic [3:0] tk);
        vec_t v;
        v.rst = rst; v.valid = valid; v.ch = ch; v.ratio = ratio; v.en = en; v.rl = rl;
        v.chk = chk; v.exp_rdy = rdy; v.exp_2x = x2; v.exp_div = div; v.exp_tick = tk;
        tbl.push_back(v);
    endfunction

    function automatic void idle(input logic [2:0] ch, input logic rdy, input logic x2,
                                 input logic [3:0] div, input logic [3:0] tk);
        add(1'b1, 1'b0, ch, 6'd0, 1'b1, 1'b0, 1'b1, rdy, x2, div, tk);
    endfunction

    function automatic void req(input logic [2:0] ch, input logic [5:0] ratio, input logic en,
                                input logic rl, input logic rdy, input logic x2,
                                input logic [3:0] div, input logic [3:0] tk);
        add(1'b1, 1'b1, ch, ratio, en, rl, 1'b1, rdy, x2, div, tk);
    endfunction

    function automatic void skip(input int n);
        for (int k = 0; k < n; k++)
            add(1'b1, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    endfunction

    function automatic void rst_edge(input logic chk);
        add(1'b0, 1'b0, 3'd1, 6'd0, 1'b1, 1'b0, chk, 1'b1, 1'b1, 4'h0, 4'h0);
    endfunction

    task automatic set_in(input logic rst, input logic valid, input logic [2:0] ch,
                          input logic [5:0] ratio, input logic en, input logic rl);
        reset_in = rst; cfg_valid = valid; cfg_ch = ch; cfg_ratio = ratio;
        cfg_en = en; realign = rl;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rdy(input string name, input logic exp);
        n_vec++;
        if (cfg_ready !== exp) begin
            n_bad++;
            $display("FAIL %s: cfg_ready=%b expected %b", name, cfg_ready, exp);
        end
    endtask

    task automatic check_out(input string name, input logic x2, input logic [3:0] div,
                             input logic [3:0] tk);
        n_vec++;
        if (clock_2x !== x2 || clock_div !== div || tick !== tk) begin
            n_bad++;
            $display("FAIL %s: got 2x=%b div=%b tick=%b, expected 2x=%b div=%b tick=%b",
                     name, clock_2x, clock_div, tick, x2, div, tk);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        set_in(v.rst, v.valid, v.ch, v.ratio, v.en, v.rl);
        #1;
        if (v.chk) check_rdy($sformatf("vec%0d_rdy", idx), v.exp_rdy);
        clk_edge();
        if (v.chk) check_out($sformatf("vec%0d_out", idx), v.exp_2x, v.exp_div, v.exp_tick);
    endtask

    initial begin
        set_in(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0);

        // Scenario A: reset release, ch1 ratio 3, ch2 disable then re-enable at ratio 2,
        // ch1 request held while pending.
        rst_edge(1'b0);
        rst_edge(1'b1);
        idle(3'd0, 1'b1, 1'b0, 4'h0, 4'h0);                      // e1
        req(3'd1, 6'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);     // e2 accept
        req(3'd1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);     // e3 held, stalled
        req(3'd1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);     // e4
        req(3'd1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF);     // e5
        req(3'd1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0);     // e6
        req(3'd2, 6'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0);     // e7 ch2 disable
        req(3'd1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0);     // e8
        req(3'd1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0);     // e9
        req(3'd1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);     // e10 apply
        idle(3'd1, 1'b1, 1'b0, 4'h0, 4'h0);                      // e11
        idle(3'd0, 1'b1, 1'b1, 4'h0, 4'h0);                      // e12
        idle(3'd0, 1'b1, 1'b0, 4'b0010, 4'b0010);                // e13
        idle(3'd0, 1'b1, 1'b1, 4'b0010, 4'b0000);                // e14
        idle(3'd0, 1'b1, 1'b0, 4'b1011, 4'b1001);                // e15
        idle(3'd0, 1'b1, 1'b1, 4'b1001, 4'b0000);                // e16
        idle(3'd0, 1'b1, 1'b0, 4'b1001, 4'b0000);                // e17
        idle(3'd0, 1'b1, 1'b1, 4'b1001, 4'b0000);                // e18
        idle(3'd0, 1'b1, 1'b0, 4'b1011, 4'b0010);                // e19
        req(3'd2, 6'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010, 4'b0000); // e20 ch2 re-enable
        idle(3'd2, 1'b0, 1'b0, 4'b0010, 4'b0000);                // e21 apply
        idle(3'd2, 1'b1, 1'b1, 4'b0000, 4'b0000);                // e22
        idle(3'd0, 1'b1, 1'b0, 4'b0100, 4'b0100);                // e23
        idle(3'd0, 1'b1, 1'b1, 4'b0100, 4'b0000);                // e24
        idle(3'd0, 1'b1, 1'b0, 4'b1011, 4'b1011);                // e25
        idle(3'd0, 1'b1, 1'b1, 4'b1011, 4'b0000);                // e26
        idle(3'd0, 1'b1, 1'b0, 4'b1111, 4'b0100);                // e27
        idle(3'd0, 1'b1, 1'b1, 4'b1101, 4'b0000);                // e28

        // Scenario B: ch3 ratio 2, ch2 pending at realign, ch1 ratio 0 with realign.
        rst_edge(1'b0);
        rst_edge(1'b0);
        req(3'd3, 6'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);     // e1
        skip(3);
        idle(3'd0, 1'b1, 1'b0, 4'hF, 4'hF);                      // e5
        skip(4);
        idle(3'd3, 1'b0, 1'b1, 4'h0, 4'h0);                      // e10 apply
        req(3'd2, 6'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);     // e11 ch2 pends
        req(3'd1, 6'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);     // e12 realign
        idle(3'd2, 1'b1, 1'b0, 4'b0010, 4'b0010);                // e13
        idle(3'd0, 1'b1, 1'b1, 4'b1000, 4'b1000);                // e14
        idle(3'd0, 1'b1, 1'b0, 4'b1110, 4'b0110);                // e15
        idle(3'd0, 1'b1, 1'b1, 4'b0100, 4'b0000);                // e16
        idle(3'd0, 1'b1, 1'b0, 4'b0111, 4'b0011);                // e17
        idle(3'd0, 1'b1, 1'b1, 4'b1001, 4'b1000);                // e18
        add(1'b1, 1'b0, 3'd0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0); // e19 realign
        idle(3'd0, 1'b1, 1'b0, 4'b0010, 4'b0010);                // e20

        // Scenario C: out-of-range channel 5 is accepted and dropped.
        rst_edge(1'b0);
        rst_edge(1'b0);
        req(3'd5, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);     // e1
        skip(3);
        idle(3'd1, 1'b1, 1'b0, 4'hF, 4'hF);                      // e5
        skip(4);
        idle(3'd0, 1'b1, 1'b1, 4'h0, 4'h0);                      // e10
        skip(4);
        idle(3'd1, 1'b1, 1'b0, 4'hF, 4'hF);                      // e15

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // Reset asserted mid-period while ch0 holds a pending ratio-2 config.
        set_in(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0);
        clk_edge();
        clk_edge();
        set_in(1'b1, 1'b1, 3'd0, 6'd2, 1'b1, 1'b0);
        #1 check_rdy("midrst_accept_rdy", 1'b1);
        clk_edge();
        set_in(1'b1, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0);
        for (int e = 2; e <= 6; e++) clk_edge();
        check_rdy("midrst_pending_rdy", 1'b0);
        check_out("midrst_before", 1'b1, 4'hF, 4'h0);
        set_in(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0);
        clk_edge();
        check_out("midrst_reset_out", 1'b1, 4'h0, 4'h0);
        check_rdy("midrst_cleared_rdy", 1'b1);
        set_in(1'b1, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0);
        for (int e = 1; e <= 15; e++) begin
            logic       x2;
            logic [3:0] div;
            logic [3:0] tk;
            clk_edge();
            x2  = (e % 2 == 0);
            div = ((e / 5) % 2 == 1) ? 4'hF : 4'h0;
            tk  = ((e % 5 == 0) && ((e / 5) % 2 == 1)) ? 4'hF : 4'h0;
            check_out($sformatf("midrst_after_e%0d", e), x2, div, tk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
